seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexes one shared hex-to-seven-segment decoder across NUM_DIGITS common-anode digits.
- Each cycle it presents one nibble to the decoder's 4-bit input and drives the matching active-low anode.
- A blank gap between digits prevents ghosting.
- Display value updates tear-free, only at frame boundaries.

---
 rtl/seven_seg_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Purpose  : Multiplexed common-anode 7-seg scanner, one shared hex decoder.
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] staging_val;
  logic [NUM_DIGITS-1:0]   staging_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    frame_end;
  logic                    lit;

  assign frame_end = (state == ST_SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
  assign lit       = (state == ST_SHOW) && digit_en[idx] && !suppress[idx];

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the most significant digit; a lit decimal point keeps a zero digit visible.
  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (shadow_val[4*i +: 4] == 4'h0);
      suppress[i] = zero_run && !shadow_dp[i];
    end
  end
`else
  assign suppress = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state <= ST_SHOW;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      if (cnt == SHOW_LAST) begin
        state <= ST_BLANK;
        cnt   <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A load landing on the frame-end edge bypasses staging so it is not lost for a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging_val <= '0;
      staging_dp  <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (load) begin
        staging_val <= value_in;
        staging_dp  <= dp_in;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          shadow_val <= value_in;
          shadow_dp  <= dp_in;
          load_ack   <= 1'b1;
        end else if (pending) begin
          shadow_val <= staging_val;
          shadow_dp  <= staging_dp;
          load_ack   <= 1'b1;
        end else begin
          load_ack <= 1'b0;
        end
      end else begin
        load_ack <= 1'b0;
        if (load) begin
          pending <= 1'b1;
        end
      end
    end
  end

  // hex_out is refreshed one cycle into BLANK so a frame-boundary commit is already visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_n <= '1;
      dp_n    <= 1'b1;
      hex_out <= 4'h0;
    end else begin
      anode_n <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      dp_n    <= lit ? ~shadow_dp[idx] : 1'b1;
      if ((state == ST_BLANK) && (cnt == '0)) begin
        hex_out <= shadow_val[{idx, 2'b00} +: 4];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seven_seg_scan_ctrl (4 digits,
//            SHOW=8, BLANK=2, 40-cycle frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  hex_out;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .load      (load),
    .load_ack  (load_ack),
    .hex_out   (hex_out),
    .anode_n   (anode_n),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    reset = 1'b1;
    step(3);
    n_cmp++; if (anode_n !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b want 1111", anode_n); end
    n_cmp++; if (dp_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp_n); end
    n_cmp++; if (hex_out !== 4'h0) begin n_bad++; $display("FAIL reset_hex: got %h want 0", hex_out); end
    n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", load_ack); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    reset = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step(1);
      exp_an = (c >= 3 && c <= 10) ? 4'b1110 : ((c == 13) ? 4'b1101 : 4'b1111);
      n_cmp++;
      if (anode_n !== exp_an) begin
        n_bad++; $display("FAIL startup_anode c=%0d: got %b want %b", c, anode_n, exp_an);
      end
    end
  endtask

  // Entered at cycle 13 after reset release; the first frame_done is due at cycle 40.
  task automatic test_load_commit();
    logic [15:0] val;
    logic [3:0]  dpv, one, exp_an, exp_hex;
    logic        exp_dp, lit, seen;
    int          waited, d, ph;
    val = 16'h12AF; dpv = 4'b0100; one = 4'b0001;
    value_in = val; dp_in = dpv; load = 1'b1;
    step(1);
    load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
    seen = 1'b0; waited = 0;
    while (!seen && waited < 60) begin
      step(1); waited++;
      if (frame_done === 1'b1) seen = 1'b1;
      else begin
        n_cmp++; if (hex_out !== 4'h0 || dp_n !== 1'b1 || load_ack !== 1'b0) begin
          n_bad++; $display("FAIL load_early: hex %h dp %b ack %b want 0 1 0", hex_out, dp_n, load_ack);
        end
      end
    end
    n_cmp++; if (!seen || waited != 26) begin n_bad++; $display("FAIL load_fd_time: got %0d want 26", waited); end
    n_cmp++; if (load_ack !== 1'b1) begin n_bad++; $display("FAIL load_ack: got %b want 1", load_ack); end
    for (int r = 1; r <= 40; r++) begin
      step(1);
      d = (r - 1) / 10; ph = (r - 1) % 10;
      lit = (ph >= 2);
      exp_hex = val[4*d +: 4];
      exp_an  = lit ? ~(one << d) : 4'b1111;
      exp_dp  = lit ? ~dpv[d] : 1'b1;
      n_cmp++; if (hex_out !== exp_hex) begin n_bad++; $display("FAIL frame_hex r=%0d: got %h want %h", r, hex_out, exp_hex); end
      n_cmp++; if (anode_n !== exp_an) begin n_bad++; $display("FAIL frame_anode r=%0d: got %b want %b", r, anode_n, exp_an); end
      n_cmp++; if (dp_n !== exp_dp) begin n_bad++; $display("FAIL frame_dp r=%0d: got %b want %b", r, dp_n, exp_dp); end
      n_cmp++; if (frame_done !== (r == 40)) begin n_bad++; $display("FAIL frame_fd r=%0d: got %b", r, frame_done); end
      n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL frame_ack r=%0d: got %b want 0", r, load_ack); end
    end
  endtask

  // Entered on a frame_done cycle (frame offset 0).
  task automatic test_back_to_back();
    int acks, waited;
    logic seen;
    step(5);
    value_in = 16'h1111; load = 1'b1; step(1); load = 1'b0;
    step(8);
    value_in = 16'h2222; load = 1'b1; step(1); load = 1'b0; value_in = 16'h0;
    acks = 0; waited = 0; seen = 1'b0;
    while (!seen && waited < 40) begin
      step(1); waited++;
      if (load_ack === 1'b1) acks++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen || waited != 25) begin n_bad++; $display("FAIL coal_fd_time: got %0d want 25", waited); end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL coal_acks: got %0d want 1", acks); end
    for (int r = 1; r <= 40; r++) begin
      step(1);
      n_cmp++; if (hex_out !== 4'h2) begin n_bad++; $display("FAIL coal_hex r=%0d: got %h want 2", r, hex_out); end
      n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL coal_extra_ack r=%0d: got %b want 0", r, load_ack); end
    end
  endtask

  // Entered on a frame_done cycle; leaves at frame offset 5.
  task automatic test_disabled_digits();
    int n0, n2;
    digit_en = 4'b0101;
    n0 = 0; n2 = 0;
    for (int r = 1; r <= 80; r++) begin
      step(1);
      if (anode_n === 4'b1110) n0++;
      if (anode_n === 4'b1011) n2++;
      n_cmp++; if (anode_n !== 4'b1110 && anode_n !== 4'b1011 && anode_n !== 4'b1111) begin
        n_bad++; $display("FAIL en_anode r=%0d: got %b", r, anode_n);
      end
      n_cmp++; if (frame_done !== (r == 40 || r == 80)) begin n_bad++; $display("FAIL en_fd r=%0d: got %b", r, frame_done); end
    end
    n_cmp++; if (n0 != 16 || n2 != 16) begin n_bad++; $display("FAIL en_counts: got %0d/%0d want 16/16", n0, n2); end
    digit_en = 4'b0000;
    step(3);
    value_in = 16'h5555; dp_in = 4'hF; load = 1'b1; step(1); load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
    for (int r = 5; r <= 40; r++) begin
      step(1);
      n_cmp++; if (anode_n !== 4'b1111 || dp_n !== 1'b1) begin
        n_bad++; $display("FAIL dark_anode r=%0d: got %b dp %b want 1111 1", r, anode_n, dp_n);
      end
    end
    n_cmp++; if (load_ack !== 1'b1 || frame_done !== 1'b1) begin
      n_bad++; $display("FAIL dark_commit: ack %b fd %b want 1 1", load_ack, frame_done);
    end
    digit_en = 4'b1111;
    step(5);
    n_cmp++; if (hex_out !== 4'h5) begin n_bad++; $display("FAIL dark_hex: got %h want 5", hex_out); end
  endtask

  // Entered at frame offset 5.
  task automatic test_reset_mid_scan();
    logic [3:0] exp_an;
    step(35);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL rm_fd_align: got %b want 1", frame_done); end
    step(2);
    value_in = 16'hABCD; dp_in = 4'hF; load = 1'b1; step(1); load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
    step(22);
    n_cmp++; if (anode_n !== 4'b1011) begin n_bad++; $display("FAIL rm_pre_anode: got %b want 1011", anode_n); end
    reset = 1'b1; step(1); reset = 1'b0;
    n_cmp++; if (anode_n !== 4'b1111 || hex_out !== 4'h0 || dp_n !== 1'b1) begin
      n_bad++; $display("FAIL rm_reset_out: anode %b hex %h dp %b", anode_n, hex_out, dp_n);
    end
    for (int c = 1; c <= 90; c++) begin
      step(1);
      n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL rm_ack c=%0d: got %b want 0", c, load_ack); end
      n_cmp++; if (hex_out !== 4'h0) begin n_bad++; $display("FAIL rm_hex c=%0d: got %h want 0", c, hex_out); end
      n_cmp++; if (frame_done !== (c == 40 || c == 80)) begin n_bad++; $display("FAIL rm_fd c=%0d: got %b", c, frame_done); end
      if (c <= 13) begin
        exp_an = (c >= 3 && c <= 10) ? 4'b1110 : ((c == 13) ? 4'b1101 : 4'b1111);
        n_cmp++; if (anode_n !== exp_an) begin n_bad++; $display("FAIL rm_anode c=%0d: got %b want %b", c, anode_n, exp_an); end
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  // Entered at frame offset 10.
  task automatic test_leading_zero();
    logic [15:0] vals [2];
    logic [3:0]  dps [2];
    logic [3:0]  sups [2];
    logic [3:0]  one, exp_an;
    logic        lit, exp_dp, seen;
    int          waited, d, ph;
    vals[0] = 16'h0070; dps[0] = 4'b0000; sups[0] = 4'b1100;
    vals[1] = 16'h0000; dps[1] = 4'b1000; sups[1] = 4'b0110;
    one = 4'b0001;
    for (int t = 0; t < 2; t++) begin
      value_in = vals[t]; dp_in = dps[t]; load = 1'b1; step(1);
      load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
      seen = 1'b0; waited = 0;
      while (!seen && waited < 50) begin
        step(1); waited++;
        if (frame_done === 1'b1) seen = 1'b1;
      end
      n_cmp++; if (!seen || load_ack !== 1'b1) begin n_bad++; $display("FAIL lzb_commit t=%0d: ack %b", t, load_ack); end
      for (int r = 1; r <= 40; r++) begin
        step(1);
        d = (r - 1) / 10; ph = (r - 1) % 10;
        lit = (ph >= 2) && !sups[t][d];
        exp_an = lit ? ~(one << d) : 4'b1111;
        exp_dp = lit ? ~dps[t][d] : 1'b1;
        n_cmp++; if (anode_n !== exp_an || dp_n !== exp_dp) begin
          n_bad++; $display("FAIL lzb_anode t=%0d r=%0d: got %b/%b want %b/%b", t, r, anode_n, dp_n, exp_an, exp_dp);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_disabled_digits();
    test_reset_mid_scan();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
